io_word_bridge: RTL and testbench
=================================

Name: io_word_bridge

Overview:
Sits between the CPU core and the UART IO controller's CPU-side byte streams. It turns CPU read/write requests of 1 or 4 bytes into sequences of byte handshakes. Received bytes are packed into a 32-bit result, and outgoing 32-bit words are split into bytes. This lets the core execute byte and word IO instructions without byte-level sequencing in the pipeline.

Parameters:
BIG_ENDIAN, 1, 1: first byte on the wire is bits [31:24] of the word; 0: first byte is bits [7:0].

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
io_in_data  input  8  byte from IO controller receive buffer
io_in_vld  input  1  receive byte valid
io_in_rdy  output  1  bridge accepts receive byte
io_out_data  output  8  byte to IO controller transmit buffer
io_out_vld  output  1  transmit byte valid
io_out_rdy  input  1  IO controller accepts transmit byte
cpu_in_req  input  1  start a read (sampled only when read side idle)
cpu_in_word  input  1  1 = read 4 bytes, 0 = read 1 byte
cpu_in_data  output  32  assembled read result
cpu_in_busy  output  1  read in progress
cpu_in_done  output  1  one-cycle pulse: cpu_in_data updated
cpu_out_req  input  1  start a write (sampled only when write side idle)
cpu_out_word  input  1  1 = send 4 bytes, 0 = send cpu_out_data[7:0] only
cpu_out_data  input  32  word to send
cpu_out_busy  output  1  write in progress
cpu_out_done  output  1  one-cycle pulse: last byte handed off

Behaviour:
- Clock and reset: single clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: every output is 0, both FSMs are IDLE, and all counters and shift registers are cleared.
- Reset asserted mid-operation discards partial bytes immediately. No done pulse is produced.
- Handshake: a byte transfers at a rising edge where vld && rdy are both high. The IO controller may deassert vld/rdy for a cycle between bytes, and the bridge must tolerate any such gaps.

Read FSM, states IDLE and COLLECT:
- IDLE: if cpu_in_req is high, latch cpu_in_word, clear the byte counter and shift register, and go to COLLECT. In IDLE, cpu_in_busy = 0 and io_in_rdy = 0.
- COLLECT: io_in_rdy = 1 and cpu_in_busy = 1. On each accepted byte, store it into the shift register and increment a 2-bit counter.
- Last byte (1st in byte mode, 4th in word mode):
  - the next cpu_in_data is written at the same edge;
  - the FSM returns to IDLE;
  - cpu_in_done is high for exactly the following cycle.
- cpu_in_data values:
  - byte mode: {24'b0, byte}, independent of BIG_ENDIAN;
  - word mode, BIG_ENDIAN=1: b0 in [31:24], b1 in [23:16], b2 in [15:8], b3 in [7:0];
  - word mode, BIG_ENDIAN=0: b0 in [7:0], b1 in [15:8], b2 in [23:16], b3 in [31:24].
- cpu_in_data holds its value until the next completion and is never visibly partial.
- cpu_in_req while busy is ignored. A request in the done cycle is accepted, because the FSM is already IDLE.
- Minimum latency: word read = 4 cycles from the first accepted byte to done; byte read = done one cycle after the handshake.

Write FSM, states IDLE and SEND:
- IDLE: on cpu_out_req, latch cpu_out_data and cpu_out_word, set the counter to 0, and go to SEND.
- SEND: io_out_vld = 1 and cpu_out_busy = 1.
- io_out_data is the current byte:
  - word mode: order [31:24]..[7:0] if BIG_ENDIAN=1, reverse if 0;
  - byte mode: the latched [7:0].
- io_out_data is stable while io_out_vld is high and the handshake has not occurred.
- On each handshake, advance the counter.
- After the last byte: io_out_vld goes to 0 at the same edge, the FSM returns to IDLE, and cpu_out_done pulses the next cycle.
- Changes on cpu_out_data during SEND have no effect.

General:
- The read and write FSMs are fully independent and may run simultaneously.
- No byte is dropped or duplicated under any pattern of vld/rdy gaps.
- Counter wrap: the counter is 2 bits and is never advanced past the terminal count.

Test Plan:
- Word read, BIG_ENDIAN=1: cpu_in_req with word=1, then feed 0x12, 0x34, 0x56, 0x78 with 1-cycle vld gaps -> single cpu_in_done pulse, cpu_in_data=0x12345678, busy low in the done cycle.
- Byte read: req with word=0, feed 0xA5 -> cpu_in_data=0x000000A5, done one cycle after the handshake, and io_in_rdy low afterward while a 0x11 stays pending.
- Word write, BIG_ENDIAN=0: cpu_out_data=0xDEADBEEF, io_out_rdy toggling 1-of-2 cycles -> io_out_data sequence EF, BE, AD, DE exactly once each, then cpu_out_done.
- Concurrent: a word read and a word write started in the same cycle with random rdy/vld stalls -> both complete with correct data; a req asserted while busy is ignored.
- Back-to-back: a new cpu_in_req in the cpu_in_done cycle -> second read starts with no lost byte; 8 streamed bytes yield two correct words.
- Reset mid-word after 2 bytes read -> all outputs 0 asynchronously; a subsequent word read returns only post-reset bytes.

Source files
------------

// File: rtl/io_word_bridge.sv
// Bridges CPU byte/word IO requests onto the UART controller's CPU-side byte streams.
// Independent read (byte assembly) and write (byte split) state machines.
module io_word_bridge #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_in_data,
  input  logic        io_in_vld,
  output logic        io_in_rdy,
  output logic [7:0]  io_out_data,
  output logic        io_out_vld,
  input  logic        io_out_rdy,
  input  logic        cpu_in_req,
  input  logic        cpu_in_word,
  output logic [31:0] cpu_in_data,
  output logic        cpu_in_busy,
  output logic        cpu_in_done,
  input  logic        cpu_out_req,
  input  logic        cpu_out_word,
  input  logic [31:0] cpu_out_data,
  output logic        cpu_out_busy,
  output logic        cpu_out_done
);

  typedef enum logic {RD_IDLE = 1'b0, RD_COLLECT = 1'b1} rd_state_t;
  typedef enum logic {WR_IDLE = 1'b0, WR_SEND = 1'b1} wr_state_t;

  rd_state_t   rd_state, rd_state_nxt;
  logic        rd_word;
  logic [1:0]  rd_cnt;
  logic [31:0] rd_shift;
  logic [31:0] rd_data;
  logic        rd_done;
  logic        rd_hs, rd_last;

  wr_state_t   wr_state, wr_state_nxt;
  logic        wr_word;
  logic [1:0]  wr_cnt;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        wr_hs, wr_last;

  // Big-endian shifts left so the first byte ends in [31:24]; little-endian
  // shifts right so the first byte ends in [7:0].
  function automatic logic [31:0] shift_in(input logic [31:0] sh, input logic [7:0] b);
    if (BIG_ENDIAN) shift_in = {sh[23:0], b};
    else            shift_in = {b, sh[31:8]};
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] cnt,
                                           input logic word);
    logic [1:0] idx;
    idx = BIG_ENDIAN ? ~cnt : cnt;
    if (!word) idx = 2'd0;
    case (idx)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

  // ---------------- read side ----------------
  assign rd_hs       = (rd_state == RD_COLLECT) && io_in_vld;
  assign rd_last     = rd_hs && (!rd_word || (rd_cnt == 2'd3));
  assign io_in_rdy   = (rd_state == RD_COLLECT);
  assign cpu_in_busy = (rd_state == RD_COLLECT);
  assign cpu_in_data = rd_data;
  assign cpu_in_done = rd_done;

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE:    if (cpu_in_req) rd_state_nxt = RD_COLLECT;
      RD_COLLECT: if (rd_last)    rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state <= RD_IDLE;
      rd_word  <= 1'b0;
      rd_cnt   <= 2'd0;
      rd_shift <= 32'h0;
      rd_data  <= 32'h0;
      rd_done  <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_done  <= rd_last;
      if ((rd_state == RD_IDLE) && cpu_in_req) begin
        rd_word  <= cpu_in_word;
        rd_cnt   <= 2'd0;
        rd_shift <= 32'h0;
      end else if (rd_hs) begin
        if (rd_last) begin
          // Result is published whole on the final byte; the counter parks at 0.
          rd_cnt   <= 2'd0;
          rd_shift <= 32'h0;
          rd_data  <= rd_word ? shift_in(rd_shift, io_in_data) : {24'h0, io_in_data};
        end else begin
          rd_cnt   <= rd_cnt + 2'd1;
          rd_shift <= shift_in(rd_shift, io_in_data);
        end
      end
    end
  end

  // ---------------- write side ----------------
  assign wr_hs        = (wr_state == WR_SEND) && io_out_rdy;
  assign wr_last      = wr_hs && (!wr_word || (wr_cnt == 2'd3));
  assign io_out_vld   = (wr_state == WR_SEND);
  assign cpu_out_busy = (wr_state == WR_SEND);
  assign io_out_data  = (wr_state == WR_SEND) ? pick_byte(wr_data, wr_cnt, wr_word) : 8'h00;
  assign cpu_out_done = wr_done;

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WR_IDLE: if (cpu_out_req) wr_state_nxt = WR_SEND;
      WR_SEND: if (wr_last)     wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state <= WR_IDLE;
      wr_word  <= 1'b0;
      wr_cnt   <= 2'd0;
      wr_data  <= 32'h0;
      wr_done  <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_done  <= wr_last;
      if ((wr_state == WR_IDLE) && cpu_out_req) begin
        wr_word <= cpu_out_word;
        wr_data <= cpu_out_data;
        wr_cnt  <= 2'd0;
      end else if (wr_hs) begin
        wr_cnt <= wr_last ? 2'd0 : wr_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_io_word_bridge.sv
// Self-checking bench: drives a big-endian and a little-endian bridge from the same
// stimulus and compares both against a byte-queue reference model.
module tb_io_word_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [7:0]  io_in_data;
  logic        io_in_vld, io_out_rdy;
  logic        cpu_in_req, cpu_in_word, cpu_out_req, cpu_out_word;
  logic [31:0] cpu_out_data;

  logic        io_in_rdy_be, io_out_vld_be, cpu_in_busy_be, cpu_in_done_be, cpu_out_busy_be, cpu_out_done_be;
  logic [7:0]  io_out_data_be;
  logic [31:0] cpu_in_data_be;
  logic        io_in_rdy_le, io_out_vld_le, cpu_in_busy_le, cpu_in_done_le, cpu_out_busy_le, cpu_out_done_le;
  logic [7:0]  io_out_data_le;
  logic [31:0] cpu_in_data_le;

  io_word_bridge #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rstn(rstn),
    .io_in_data(io_in_data), .io_in_vld(io_in_vld), .io_in_rdy(io_in_rdy_be),
    .io_out_data(io_out_data_be), .io_out_vld(io_out_vld_be), .io_out_rdy(io_out_rdy),
    .cpu_in_req(cpu_in_req), .cpu_in_word(cpu_in_word), .cpu_in_data(cpu_in_data_be),
    .cpu_in_busy(cpu_in_busy_be), .cpu_in_done(cpu_in_done_be),
    .cpu_out_req(cpu_out_req), .cpu_out_word(cpu_out_word), .cpu_out_data(cpu_out_data),
    .cpu_out_busy(cpu_out_busy_be), .cpu_out_done(cpu_out_done_be)
  );

  io_word_bridge #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rstn(rstn),
    .io_in_data(io_in_data), .io_in_vld(io_in_vld), .io_in_rdy(io_in_rdy_le),
    .io_out_data(io_out_data_le), .io_out_vld(io_out_vld_le), .io_out_rdy(io_out_rdy),
    .cpu_in_req(cpu_in_req), .cpu_in_word(cpu_in_word), .cpu_in_data(cpu_in_data_le),
    .cpu_in_busy(cpu_in_busy_le), .cpu_in_done(cpu_in_done_le),
    .cpu_out_req(cpu_out_req), .cpu_out_word(cpu_out_word), .cpu_out_data(cpu_out_data),
    .cpu_out_busy(cpu_out_busy_le), .cpu_out_done(cpu_out_done_le)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  feed[$];
  logic [7:0]  oq_be[$], oq_le[$];
  logic [31:0] rres_be[$], rres_le[$];
  int  in_done_n = 0, out_done_n = 0, cyc = 0, hs_edge = -1, done_cyc = -2;
  bit  busy_at_done, sync_err, stab_err, rdy_seen, prev_stall;
  logic [7:0] prev_be, prev_le;

  // Reference model: byte order on the wire -> CPU word.
  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input bit word, input bit be);
    if (!word) return {24'h0, b0};
    if (be) return (32'(b0) << 24) | (32'(b1) << 16) | (32'(b2) << 8) | 32'(b3);
    return (32'(b3) << 24) | (32'(b2) << 16) | (32'(b1) << 8) | 32'(b0);
  endfunction

  // Reference model: i-th byte expected on the wire for a write.
  function automatic logic [7:0] wbyte(input logic [31:0] d, input bit word, input bit be, input int i);
    if (!word) return d[7:0];
    return 8'(d >> (be ? 8 * (3 - i) : 8 * i));
  endfunction

  // One clock of stimulus plus bookkeeping; entered and left at posedge+1.
  task automatic cycle(input bit vld_en, input bit rdy_en);
    io_in_vld  = vld_en && (feed.size() > 0);
    io_in_data = (feed.size() > 0) ? feed[0] : 8'($urandom);
    io_out_rdy = rdy_en;
    #2;
    if (io_in_rdy_be !== io_in_rdy_le || io_out_vld_be !== io_out_vld_le ||
        cpu_in_busy_be !== cpu_in_busy_le || cpu_out_busy_be !== cpu_out_busy_le) sync_err = 1;
    if (io_in_rdy_be) rdy_seen = 1;
    if (prev_stall && io_out_vld_be && (io_out_data_be !== prev_be || io_out_data_le !== prev_le))
      stab_err = 1;
    prev_stall = io_out_vld_be && !io_out_rdy;
    prev_be = io_out_data_be;
    prev_le = io_out_data_le;
    if (io_in_vld && io_in_rdy_be) begin
      void'(feed.pop_front());
      hs_edge = cyc + 1;
    end
    if (io_out_vld_be && io_out_rdy) begin
      oq_be.push_back(io_out_data_be);
      oq_le.push_back(io_out_data_le);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_in_done_be !== cpu_in_done_le || cpu_out_done_be !== cpu_out_done_le) sync_err = 1;
    if (cpu_in_done_be) begin
      in_done_n++;
      rres_be.push_back(cpu_in_data_be);
      rres_le.push_back(cpu_in_data_le);
      done_cyc = cyc;
      if (cpu_in_busy_be) busy_at_done = 1;
    end
    if (cpu_out_done_be) out_done_n++;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    io_in_data = 8'h0; io_in_vld = 1'b0; io_out_rdy = 1'b0;
    cpu_in_req = 1'b0; cpu_in_word = 1'b0; cpu_out_req = 1'b0; cpu_out_word = 1'b0;
    cpu_out_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({io_in_rdy_be, io_out_data_be, io_out_vld_be, cpu_in_data_be, cpu_in_busy_be,
         cpu_in_done_be, cpu_out_busy_be, cpu_out_done_be} !== 46'h0) begin
      failures++;
      $display("FAIL reset_be outputs got in_data=%h out_data=%h rdy=%b vld=%b busy=%b/%b exp all 0",
               cpu_in_data_be, io_out_data_be, io_in_rdy_be, io_out_vld_be, cpu_in_busy_be, cpu_out_busy_be);
    end
    checks++;
    if ({io_in_rdy_le, io_out_data_le, io_out_vld_le, cpu_in_data_le, cpu_in_busy_le,
         cpu_in_done_le, cpu_out_busy_le, cpu_out_done_le} !== 46'h0) begin
      failures++;
      $display("FAIL reset_le outputs got in_data=%h out_data=%h rdy=%b vld=%b exp all 0",
               cpu_in_data_le, io_out_data_le, io_in_rdy_le, io_out_vld_le);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word_read;
    int s;
    logic [31:0] g_be, g_le;
    s = in_done_n; busy_at_done = 0; sync_err = 0;
    rres_be.delete(); rres_le.delete();
    cpu_in_word = 1'b1; cpu_in_req = 1'b1; cycle(0, 0); cpu_in_req = 1'b0;
    feed = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int k = 0; k < 40 && in_done_n == s; k++) cycle(k % 2 == 0, 0);
    repeat (4) cycle(0, 0);
    checks++;
    if (in_done_n - s != 1) begin
      failures++; $display("FAIL word_read done_pulses got=%0d exp=1", in_done_n - s);
    end
    g_be = (rres_be.size() > 0) ? rres_be[0] : 32'hxxxxxxxx;
    g_le = (rres_le.size() > 0) ? rres_le[0] : 32'hxxxxxxxx;
    checks++;
    if (g_be !== pack(8'h12, 8'h34, 8'h56, 8'h78, 1, 1)) begin
      failures++; $display("FAIL word_read_be data got=%h exp=%h", g_be, pack(8'h12, 8'h34, 8'h56, 8'h78, 1, 1));
    end
    checks++;
    if (g_le !== pack(8'h12, 8'h34, 8'h56, 8'h78, 1, 0)) begin
      failures++; $display("FAIL word_read_le data got=%h exp=%h", g_le, pack(8'h12, 8'h34, 8'h56, 8'h78, 1, 0));
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      failures++; $display("FAIL word_read busy_in_done_cycle got=1 exp=0");
    end
    checks++;
    if (sync_err !== 1'b0) begin
      failures++; $display("FAIL word_read handshake_timing endian instances diverged got=1 exp=0");
    end
  endtask

  task automatic test_byte_read;
    int s;
    logic [31:0] g_be, g_le;
    s = in_done_n;
    rres_be.delete(); rres_le.delete();
    cpu_in_word = 1'b0; cpu_in_req = 1'b1; cycle(0, 0); cpu_in_req = 1'b0;
    feed = '{8'hA5};
    for (int k = 0; k < 20 && in_done_n == s; k++) cycle(1, 0);
    g_be = (rres_be.size() > 0) ? rres_be[0] : 32'hxxxxxxxx;
    g_le = (rres_le.size() > 0) ? rres_le[0] : 32'hxxxxxxxx;
    checks++;
    if (g_be !== 32'h000000A5 || g_le !== 32'h000000A5) begin
      failures++; $display("FAIL byte_read data got be=%h le=%h exp=000000a5", g_be, g_le);
    end
    checks++;
    if (done_cyc != hs_edge) begin
      failures++; $display("FAIL byte_read latency done_cycle=%0d exp=%0d", done_cyc, hs_edge);
    end
    rdy_seen = 0;
    feed.push_back(8'h11);
    repeat (4) cycle(1, 0);
    checks++;
    if (rdy_seen !== 1'b0 || feed.size() != 1) begin
      failures++; $display("FAIL byte_read idle_rdy got rdy_seen=%b pending=%0d exp 0/1", rdy_seen, feed.size());
    end
    checks++;
    if (in_done_n - s != 1) begin
      failures++; $display("FAIL byte_read done_pulses got=%0d exp=1", in_done_n - s);
    end
    feed.delete();
  endtask

  task automatic test_write(input logic [31:0] d, input bit w, input string nm);
    int s, n;
    logic [7:0] g;
    s = out_done_n; stab_err = 0; prev_stall = 0;
    oq_be.delete(); oq_le.delete();
    cpu_out_data = d; cpu_out_word = w; cpu_out_req = 1'b1; cycle(0, 0); cpu_out_req = 1'b0;
    cpu_out_data = $urandom;
    for (int k = 0; k < 40 && out_done_n == s; k++) cycle(0, k % 2 == 1);
    repeat (3) cycle(0, 1);
    n = w ? 4 : 1;
    checks++;
    if (oq_be.size() != n || oq_le.size() != n) begin
      failures++; $display("FAIL %s byte_count got be=%0d le=%0d exp=%0d", nm, oq_be.size(), oq_le.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      g = (i < oq_be.size()) ? oq_be[i] : 8'hxx;
      checks++;
      if (g !== wbyte(d, w, 1, i)) begin
        failures++; $display("FAIL %s be_byte%0d got=%h exp=%h", nm, i, g, wbyte(d, w, 1, i));
      end
      g = (i < oq_le.size()) ? oq_le[i] : 8'hxx;
      checks++;
      if (g !== wbyte(d, w, 0, i)) begin
        failures++; $display("FAIL %s le_byte%0d got=%h exp=%h", nm, i, g, wbyte(d, w, 0, i));
      end
    end
    checks++;
    if (out_done_n - s != 1) begin
      failures++; $display("FAIL %s done_pulses got=%0d exp=1", nm, out_done_n - s);
    end
    checks++;
    if (stab_err !== 1'b0) begin
      failures++; $display("FAIL %s data_stable_during_stall got=1 exp=0", nm);
    end
  endtask

  task automatic test_concurrent;
    int s_in, s_out;
    logic [7:0] b[4];
    logic [31:0] wd, g_be, g_le;
    for (int it = 0; it < 3; it++) begin
      s_in = in_done_n; s_out = out_done_n;
      rres_be.delete(); rres_le.delete(); oq_be.delete(); oq_le.delete();
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      wd = $urandom;
      cpu_in_word = 1'b1; cpu_in_req = 1'b1;
      cpu_out_word = 1'b1; cpu_out_data = wd; cpu_out_req = 1'b1;
      cycle(0, 0);
      cpu_in_req = 1'b0; cpu_out_req = 1'b0; cpu_out_data = $urandom;
      feed = '{b[0], b[1], b[2], b[3]};
      for (int k = 0; k < 200 && (in_done_n == s_in || out_done_n == s_out); k++) begin
        cpu_in_req = (k == 1); cpu_out_req = (k == 1);
        if (k == 1) begin
          cpu_in_word = 1'b0; cpu_out_word = 1'b0; cpu_out_data = $urandom;
        end
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      cpu_in_req = 1'b0; cpu_out_req = 1'b0;
      repeat (3) cycle(0, 0);
      g_be = (rres_be.size() > 0) ? rres_be[0] : 32'hxxxxxxxx;
      g_le = (rres_le.size() > 0) ? rres_le[0] : 32'hxxxxxxxx;
      checks++;
      if (g_be !== pack(b[0], b[1], b[2], b[3], 1, 1) || g_le !== pack(b[0], b[1], b[2], b[3], 1, 0)) begin
        failures++;
        $display("FAIL concurrent%0d read got be=%h le=%h exp be=%h le=%h", it, g_be, g_le,
                 pack(b[0], b[1], b[2], b[3], 1, 1), pack(b[0], b[1], b[2], b[3], 1, 0));
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (i >= oq_be.size() || i >= oq_le.size() ||
            oq_be[i] !== wbyte(wd, 1, 1, i) || oq_le[i] !== wbyte(wd, 1, 0, i)) begin
          failures++;
          $display("FAIL concurrent%0d write_byte%0d count be=%0d le=%0d exp be=%h le=%h", it, i,
                   oq_be.size(), oq_le.size(), wbyte(wd, 1, 1, i), wbyte(wd, 1, 0, i));
        end
      end
      checks++;
      if (in_done_n - s_in != 1 || out_done_n - s_out != 1 || oq_be.size() != 4 ||
          cpu_in_busy_be !== 1'b0 || cpu_out_busy_be !== 1'b0) begin
        failures++;
        $display("FAIL concurrent%0d busy_req_ignored got done=%0d/%0d bytes=%0d busy=%b/%b exp 1/1 4 0/0",
                 it, in_done_n - s_in, out_done_n - s_out, oq_be.size(), cpu_in_busy_be, cpu_out_busy_be);
      end
    end
  endtask

  task automatic test_back_to_back;
    int s, started;
    logic [7:0] b[8];
    logic [31:0] e;
    s = in_done_n;
    rres_be.delete(); rres_le.delete();
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    feed = '{b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    cpu_in_word = 1'b1; cpu_in_req = 1'b1; cycle(0, 0); cpu_in_req = 1'b0;
    started = 1;
    for (int k = 0; k < 100 && in_done_n < s + 2; k++) begin
      cycle(1, 0);
      cpu_in_req = cpu_in_done_be && (started == 1);
      if (cpu_in_req) started = 2;
    end
    cpu_in_req = 1'b0;
    checks++;
    if (in_done_n - s != 2 || feed.size() != 0) begin
      failures++; $display("FAIL back_to_back completions got=%0d left=%0d exp 2/0", in_done_n - s, feed.size());
    end
    for (int j = 0; j < 2; j++) begin
      e = pack(b[4*j], b[4*j+1], b[4*j+2], b[4*j+3], 1, 1);
      checks++;
      if (j >= rres_be.size() || rres_be[j] !== e) begin
        failures++; $display("FAIL back_to_back be_word%0d exp=%h results=%0d", j, e, rres_be.size());
      end
      e = pack(b[4*j], b[4*j+1], b[4*j+2], b[4*j+3], 1, 0);
      checks++;
      if (j >= rres_le.size() || rres_le[j] !== e) begin
        failures++; $display("FAIL back_to_back le_word%0d exp=%h results=%0d", j, e, rres_le.size());
      end
    end
  endtask

  task automatic test_reset_mid;
    int s;
    logic [7:0] b[4];
    logic [31:0] g_be, g_le;
    cpu_in_word = 1'b1; cpu_in_req = 1'b1;
    cpu_out_word = 1'b1; cpu_out_data = $urandom; cpu_out_req = 1'b1;
    cycle(0, 0);
    cpu_in_req = 1'b0; cpu_out_req = 1'b0;
    feed = '{8'hC3, 8'h3C};
    for (int k = 0; k < 10 && feed.size() > 0; k++) cycle(1, 0);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({io_in_rdy_be, io_out_vld_be, io_out_data_be, cpu_in_busy_be, cpu_out_busy_be,
         cpu_in_done_be, cpu_out_done_be, cpu_in_data_be} !== 46'h0) begin
      failures++;
      $display("FAIL reset_mid_be async got rdy=%b vld=%b out=%h busy=%b/%b data=%h exp all 0",
               io_in_rdy_be, io_out_vld_be, io_out_data_be, cpu_in_busy_be, cpu_out_busy_be, cpu_in_data_be);
    end
    checks++;
    if ({io_in_rdy_le, io_out_vld_le, io_out_data_le, cpu_in_busy_le, cpu_out_busy_le,
         cpu_in_done_le, cpu_out_done_le, cpu_in_data_le} !== 46'h0) begin
      failures++;
      $display("FAIL reset_mid_le async got rdy=%b vld=%b out=%h data=%h exp all 0",
               io_in_rdy_le, io_out_vld_le, io_out_data_le, cpu_in_data_le);
    end
    @(posedge clk);
    #1;
    cyc++;
    rstn = 1'b1;
    prev_stall = 0;
    s = in_done_n;
    rres_be.delete(); rres_le.delete();
    cycle(0, 1);
    checks++;
    if (cpu_out_busy_be !== 1'b0 || in_done_n != s) begin
      failures++; $display("FAIL reset_mid after_release got out_busy=%b done=%0d exp 0/0", cpu_out_busy_be, in_done_n - s);
    end
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    cpu_in_word = 1'b1; cpu_in_req = 1'b1; cycle(0, 0); cpu_in_req = 1'b0;
    feed = '{b[0], b[1], b[2], b[3]};
    for (int k = 0; k < 60 && in_done_n == s; k++) cycle(1'($urandom_range(0, 1)), 0);
    g_be = (rres_be.size() > 0) ? rres_be[0] : 32'hxxxxxxxx;
    g_le = (rres_le.size() > 0) ? rres_le[0] : 32'hxxxxxxxx;
    checks++;
    if (g_be !== pack(b[0], b[1], b[2], b[3], 1, 1)) begin
      failures++; $display("FAIL reset_mid post_read_be got=%h exp=%h", g_be, pack(b[0], b[1], b[2], b[3], 1, 1));
    end
    checks++;
    if (g_le !== pack(b[0], b[1], b[2], b[3], 1, 0)) begin
      failures++; $display("FAIL reset_mid post_read_le got=%h exp=%h", g_le, pack(b[0], b[1], b[2], b[3], 1, 0));
    end
  endtask

  initial begin
    test_reset;
    test_word_read;
    test_byte_read;
    test_write(32'hDEADBEEF, 1'b1, "word_write");
    test_write($urandom, 1'b0, "byte_write");
    test_write($urandom, 1'b1, "rand_word_write");
    test_concurrent;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
